// File: rtl/be_sync_ram.sv
// ---------------------------------------------------------------------------
// be_sync_ram
//   Single-clock RAM with one byte-enable style write port and one
//   synchronous read port. The read latency (1 or 2 cycles) and the
//   same-address read-during-write result (old word or lane-merged new word)
//   are parameters. An optional hardware clear writes zero to every word
//   after reset, before any request is accepted.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   wr_valid       write request
//   wr_ready       write accepted when wr_valid && wr_ready
//   wr_addr        write address
//   wr_be          lane enables, bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH]
//   wr_data        write data
//   rd_valid       read request
//   rd_ready       read accepted when rd_valid && rd_ready
//   rd_addr        read address
//   rd_data        read data, holds its last value while rd_data_valid is low
//   rd_data_valid  rd_data carries the result of an accepted read this cycle
//   clear_busy     hardware clear sweep in progress
//
// Handshake: a request transfers on a rising edge where its valid and ready
// are both high. Ready does not depend on valid. Both readies are low for the
// whole clear sweep and high every cycle afterwards; a request presented
// while ready is low is ignored, not queued. There is no backpressure on the
// read result: rd_data_valid is a one-cycle strobe per accepted read.
// ---------------------------------------------------------------------------
module be_sync_ram #(
   parameter int DATA_WIDTH     = 32,
   parameter int LANE_WIDTH     = 8,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int RD_LATENCY     = 1,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter int NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_LANES-1:0]  wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  clear_busy
);

   // ------------------------------------------------------------------------
   // Control FSM: CLEAR sweeps the array, READY serves requests.
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   // One extra bit so that DEPTH itself is representable when DEPTH is a
   // power of two (otherwise the range compare would wrap to zero).
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [ADDR_WIDTH-1:0] clr_addr_nxt;
   logic                  ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RESET_STATE;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      ready        = 1'b0;
      clear_busy   = 1'b0;
      case (state)
         ST_CLEAR: begin
            clear_busy   = 1'b1;
            clr_addr_nxt = clr_addr + 1'b1;
            // The last word is zeroed on this edge; leave on the same edge
            // so the sweep takes exactly DEPTH cycles.
            if (clr_addr == LAST_ADDR) begin
               state_nxt    = ST_READY;
               clr_addr_nxt = '0;
            end
         end
         ST_READY: begin
            ready = 1'b1;
         end
      endcase
   end

   assign wr_ready = ready;
   assign rd_ready = ready;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic wr_acc;
   logic rd_acc;
   logic wr_in_range;
   logic rd_in_range;

   assign wr_acc      = wr_valid && ready;
   assign rd_acc      = rd_valid && ready;
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

   // ------------------------------------------------------------------------
   // Single write port shared between the clear sweep and user writes. The
   // two never compete: user writes are only accepted in READY.
   // ------------------------------------------------------------------------
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [NUM_LANES-1:0]  mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_be    = '0;
      mem_wdata = '0;
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_be    = '1;
         mem_wdata = '0;
      end else if (wr_acc && wr_in_range) begin
         mem_we    = 1'b1;
         mem_waddr = wr_addr;
         mem_be    = wr_be;
         mem_wdata = wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Storage array: one write port with lane enables, one registered read
   // port. The read register samples the array before this edge's write,
   // so it always holds the pre-write word on a same-address collision.
   // No reset here, so the array and its read register map onto a RAM macro.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] mem_rd;
   logic [ADDR_WIDTH-1:0] rd_idx;

   // Out-of-range reads still need a legal array index; their result is
   // forced to zero further down.
   assign rd_idx = rd_in_range ? rd_addr : '0;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_be[i]) begin
               mem[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <=
                  mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
      if (rd_acc) begin
         mem_rd <= mem[rd_idx];
      end
   end

   // ------------------------------------------------------------------------
   // Read stage 1: side information travelling alongside the array read.
   // For write-first collisions the write lanes are captured here and merged
   // over the old word as it leaves the array.
   // ------------------------------------------------------------------------
   logic                  s1_valid;
   logic                  s1_oor;
   logic                  s1_byp;
   logic [NUM_LANES-1:0]  s1_be;
   logic [DATA_WIDTH-1:0] s1_wdata;
   logic                  collide;

   assign collide = (WRITE_FIRST != 0) && wr_acc && wr_in_range &&
                    (wr_addr == rd_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_oor   <= 1'b0;
         s1_byp   <= 1'b0;
         s1_be    <= '0;
         s1_wdata <= '0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_oor   <= !rd_in_range;
            s1_byp   <= collide;
            s1_be    <= wr_be;
            s1_wdata <= wr_data;
         end
      end
   end

   logic [DATA_WIDTH-1:0] s1_word;

   always_comb begin
      s1_word = mem_rd;
      if (s1_byp) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (s1_be[i]) begin
               s1_word[i*LANE_WIDTH +: LANE_WIDTH] = s1_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
      if (s1_oor) begin
         s1_word = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Output. out_q holds the most recent result. With latency 2 it is the
   // extra output register; with latency 1 the stage-1 word is passed
   // straight through while valid and out_q supplies the held value after.
   // ------------------------------------------------------------------------
   logic                  s2_valid;
   logic [DATA_WIDTH-1:0] out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_q    <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_q <= s1_word;
         end
      end
   end

   assign rd_data       = (RD_LATENCY == 2) ? out_q    : (s1_valid ? s1_word : out_q);
   assign rd_data_valid = (RD_LATENCY == 2) ? s2_valid : s1_valid;

endmodule

// File: tb/tb_be_sync_ram.sv
// ---------------------------------------------------------------------------
// tb_be_sync_ram
//   Directed bench for be_sync_ram using two instances:
//     dut_a : 32-bit data, 8-bit lanes, DEPTH 16, latency 1, read-first
//     dut_b : 64-bit data, 16-bit lanes, DEPTH 12, latency 2, write-first
//   Inputs change 1 ns after a rising edge; outputs are sampled at the same
//   point, so each sample shows the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_be_sync_ram;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_a;
   logic rst_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- dut_a signals ----------------
   logic        a_wr_valid, a_wr_ready;
   logic [3:0]  a_wr_addr;
   logic [3:0]  a_wr_be;
   logic [31:0] a_wr_data;
   logic        a_rd_valid, a_rd_ready;
   logic [3:0]  a_rd_addr;
   logic [31:0] a_rd_data;
   logic        a_rd_data_valid;
   logic        a_clear_busy;

   // ---------------- dut_b signals ----------------
   logic        b_wr_valid, b_wr_ready;
   logic [3:0]  b_wr_addr;
   logic [3:0]  b_wr_be;
   logic [63:0] b_wr_data;
   logic        b_rd_valid, b_rd_ready;
   logic [3:0]  b_rd_addr;
   logic [63:0] b_rd_data;
   logic        b_rd_data_valid;
   logic        b_clear_busy;

   be_sync_ram #(
      .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(16),
      .RD_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_a),
      .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr),
      .wr_be(a_wr_be), .wr_data(a_wr_data),
      .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_addr(a_rd_addr),
      .rd_data(a_rd_data), .rd_data_valid(a_rd_data_valid),
      .clear_busy(a_clear_busy)
   );

   be_sync_ram #(
      .DATA_WIDTH(64), .LANE_WIDTH(16), .DEPTH(12),
      .RD_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_b),
      .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
      .wr_be(b_wr_be), .wr_data(b_wr_data),
      .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .rd_data_valid(b_rd_data_valid),
      .clear_busy(b_clear_busy)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
      a_wr_valid = 1'b1; a_wr_addr = addr; a_wr_be = be; a_wr_data = data;
      tick();
      a_wr_valid = 1'b0;
   endtask

   // Latency 1: result visible right after the accepting edge.
   task automatic rd_a(input logic [3:0] addr, input logic [31:0] exp, input string tag);
      a_rd_valid = 1'b1; a_rd_addr = addr;
      tick();
      a_rd_valid = 1'b0;
      check(tag, {a_rd_data_valid, a_rd_data}, {1'b1, exp});
   endtask

   task automatic wr_b(input logic [3:0] addr, input logic [3:0] be, input logic [63:0] data);
      b_wr_valid = 1'b1; b_wr_addr = addr; b_wr_be = be; b_wr_data = data;
      tick();
      b_wr_valid = 1'b0;
   endtask

   // Latency 2: result visible one edge after the accepting edge.
   task automatic rd_b(input logic [3:0] addr, input logic [63:0] exp, input string tag);
      b_rd_valid = 1'b1; b_rd_addr = addr;
      tick();
      b_rd_valid = 1'b0;
      tick();
      check(tag, {b_rd_data_valid, b_rd_data}, {1'b1, exp});
   endtask

   function automatic logic [63:0] pat(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {v, v, v, v} ^ 64'hA5A5_5A5A_0F0F_F0F0;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int          busy_cnt;
      logic        leak;
      logic [15:0] vpat;
      int          got;
      logic [63:0] e64;

      rst_a = 1'b0; rst_b = 1'b0;
      a_wr_valid = 0; a_wr_addr = '0; a_wr_be = '0; a_wr_data = '0;
      a_rd_valid = 0; a_rd_addr = '0;
      b_wr_valid = 0; b_wr_addr = '0; b_wr_be = '0; b_wr_data = '0;
      b_rd_valid = 0; b_rd_addr = '0;
      tick(); tick();

      // Reset values
      check("a_reset_outputs",
            {a_clear_busy, a_wr_ready, a_rd_ready, a_rd_data_valid, a_rd_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      check("b_reset_outputs",
            {b_clear_busy, b_wr_ready, b_rd_ready, b_rd_data_valid, b_rd_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});

      // ===== dut_a: clear sweep with requests presented throughout =====
      a_rd_valid = 1'b1; a_rd_addr = 4'd0;
      a_wr_valid = 1'b1; a_wr_addr = 4'd0; a_wr_be = 4'hF; a_wr_data = 32'hDEAD_BEEF;
      rst_a = 1'b1;
      busy_cnt = 0; leak = 1'b0;
      for (int i = 0; i < 40 && a_clear_busy; i++) begin
         busy_cnt++;
         leak = leak | a_rd_ready | a_wr_ready | a_rd_data_valid;
         tick();
      end
      a_rd_valid = 1'b0; a_wr_valid = 1'b0;
      check("a_clear_len", busy_cnt, 16);
      check("a_clear_no_accept", leak, 0);
      check("a_ready_after_clear", {a_wr_ready, a_rd_ready}, 2'b11);

      for (int i = 0; i < 16; i++) begin
         rd_a(4'(i), 32'h0, $sformatf("a_clear_rd%0d", i));
      end

      // Lane writes
      wr_a(4'd3, 4'b1111, 32'hAABB_CCDD);
      wr_a(4'd3, 4'b0101, 32'h1122_3344);
      rd_a(4'd3, 32'hAA22_CC44, "a_lane_merge");
      tick();
      check("a_hold", {a_rd_data_valid, a_rd_data}, {1'b0, 32'hAA22_CC44});

      // wr_be = 0 leaves the word untouched
      wr_a(4'd3, 4'b0000, 32'h0000_0000);
      rd_a(4'd3, 32'hAA22_CC44, "a_be_zero");

      // Read-during-write, read-first
      wr_a(4'd5, 4'b1111, 32'h0102_0304);
      a_wr_valid = 1'b1; a_wr_addr = 4'd5; a_wr_be = 4'b0011; a_wr_data = 32'hFFFF_FFFF;
      a_rd_valid = 1'b1; a_rd_addr = 4'd5;
      tick();
      a_wr_valid = 1'b0; a_rd_valid = 1'b0;
      check("a_rdw_old", {a_rd_data_valid, a_rd_data}, {1'b1, 32'h0102_0304});
      rd_a(4'd5, 32'h0102_FFFF, "a_rdw_after");

      // Different addresses in the same cycle
      a_wr_valid = 1'b1; a_wr_addr = 4'd6; a_wr_be = 4'hF; a_wr_data = 32'h1234_5678;
      a_rd_valid = 1'b1; a_rd_addr = 4'd3;
      tick();
      a_wr_valid = 1'b0; a_rd_valid = 1'b0;
      check("a_diff_addr_rd", {a_rd_data_valid, a_rd_data}, {1'b1, 32'hAA22_CC44});
      rd_a(4'd6, 32'h1234_5678, "a_diff_addr_wr");

      // Reset with a read result on the output
      a_rd_valid = 1'b1; a_rd_addr = 4'd6;
      tick();
      a_rd_valid = 1'b0;
      rst_a = 1'b0;
      #1;
      check("a_reset_midop",
            {a_rd_data_valid, a_rd_data, a_clear_busy},
            {1'b0, 32'h0, 1'b1});
      rst_a = 1'b1;

      // ===== dut_b: mid-sweep reset, read presented during clear =====
      b_rd_valid = 1'b1; b_rd_addr = 4'd0;
      rst_b = 1'b1;
      leak = 1'b0;
      for (int i = 0; i < 7; i++) begin
         leak = leak | b_rd_data_valid | b_rd_ready;
         tick();
      end
      rst_b = 1'b0;
      #1;
      check("b_pulse_reset", {b_clear_busy, b_rd_data_valid}, 2'b10);
      #1;
      rst_b = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 40 && b_clear_busy; i++) begin
         busy_cnt++;
         leak = leak | b_rd_data_valid | b_rd_ready | b_wr_ready;
         tick();
      end
      b_rd_valid = 1'b0;
      check("b_clear_len_restart", busy_cnt, 12);
      tick(); tick();
      leak = leak | b_rd_data_valid;
      check("b_clear_no_rd_valid", leak, 0);

      // Streaming at latency 2
      for (int i = 0; i < 8; i++) begin
         wr_b(4'(i), 4'hF, pat(i));
      end
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(pat(i));
      vpat = '0; got = 0;
      for (int j = 0; j < 16; j++) begin
         if (j < 8) begin
            b_rd_valid = 1'b1; b_rd_addr = 4'(j);
         end else begin
            b_rd_valid = 1'b0;
         end
         tick();
         vpat[j] = b_rd_data_valid;
         if (b_rd_data_valid) begin
            got++;
            if (exp_q.size() > 0) begin
               e64 = exp_q.pop_front();
               check($sformatf("b_stream_data%0d", got - 1), b_rd_data, e64);
            end
         end
      end
      check("b_stream_valid_pattern", vpat, 16'h01FE);
      check("b_stream_count", got, 8);

      // Read-during-write, write-first
      wr_b(4'd5, 4'hF, 64'h0001_0002_0003_0004);
      b_wr_valid = 1'b1; b_wr_addr = 4'd5; b_wr_be = 4'b0011; b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
      b_rd_valid = 1'b1; b_rd_addr = 4'd5;
      tick();
      b_wr_valid = 1'b0; b_rd_valid = 1'b0;
      tick();
      check("b_rdw_merged", {b_rd_data_valid, b_rd_data}, {1'b1, 64'h0001_0002_FFFF_FFFF});
      rd_b(4'd5, 64'h0001_0002_FFFF_FFFF, "b_rdw_after");

      // Different addresses in the same cycle
      b_wr_valid = 1'b1; b_wr_addr = 4'd2; b_wr_be = 4'hF; b_wr_data = 64'h0;
      b_rd_valid = 1'b1; b_rd_addr = 4'd3;
      tick();
      b_wr_valid = 1'b0; b_rd_valid = 1'b0;
      tick();
      check("b_diff_addr_rd", {b_rd_data_valid, b_rd_data}, {1'b1, pat(3)});
      rd_b(4'd2, 64'h0, "b_diff_addr_wr");

      // Top lane only, last in-range word, then out-of-range address
      wr_b(4'd11, 4'b1000, 64'hBEEF_0000_0000_0000);
      rd_b(4'd11, 64'hBEEF_0000_0000_0000, "b_top_lane");
      wr_b(4'd12, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
      rd_b(4'd12, 64'h0, "b_oor_read");
      rd_b(4'd11, 64'hBEEF_0000_0000_0000, "b_oor_no_alias");

      // Reset with a read in flight
      b_rd_valid = 1'b1; b_rd_addr = 4'd11;
      tick();
      b_rd_valid = 1'b0;
      rst_b = 1'b0;
      #1;
      check("b_reset_inflight", {b_rd_data_valid, b_rd_data}, {1'b0, 64'h0});
      tick();
      check("b_reset_inflight_late", b_rd_data_valid, 0);
      rst_b = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/be_sync_ram.md
Name: be_sync_ram

Overview:
- Parametrised single-clock RAM with one write port and one read port.
- Write port has per-lane write enables; disabled lanes keep their stored value.
- Read port is synchronous with configurable latency and configurable read-during-write policy.
- Optional hardware clear sweeps the whole array to zero after reset. Used as the generic memory leaf behind memory-inference tests.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per write-enable lane.
- DEPTH, 16, number of words; any value ≥ 2, not required to be a power of 2.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- RD_LATENCY, 1, cycles from an accepted read to rd_data_valid; legal values 1 or 2.
- WRITE_FIRST, 0, read-during-write to the same address: 0 returns old data, 1 returns newly merged data.
- CLEAR_ON_RESET, 1, 1 means zero all words after reset before accepting requests.
- NUM_LANES, DATA_WIDTH/LANE_WIDTH, derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_be  input  NUM_LANES  lane enables; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH].
- wr_data  input  DATA_WIDTH  write data.
- rd_valid  input  1  read request.
- rd_ready  output  1  read accepted when rd_valid && rd_ready.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data.
- rd_data_valid  output  1  rd_data is valid this cycle.
- clear_busy  output  1  hardware clear in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values (rst_n low): state CLEAR if CLEAR_ON_RESET=1, else READY; clear_busy=CLEAR_ON_RESET; wr_ready=rd_ready=!CLEAR_ON_RESET; rd_data=0; rd_data_valid=0; pipeline valids=0; clear address=0. Array contents are not reset asynchronously.
- State CLEAR:
  - Each cycle writes 0 to the word at the clear address, then increments it.
  - After writing word DEPTH-1, moves to READY on the next edge.
  - Sweep takes exactly DEPTH cycles from reset release.
  - wr_ready=rd_ready=0 throughout; requests are ignored, not queued.
- State READY:
  - wr_ready=rd_ready=1 every cycle; no backpressure.
  - Stays in READY until rst_n is asserted.
- Write: on an accepted write, for each lane i with wr_be[i]=1, mem[wr_addr] lane i takes the wr_data lane; other lanes are unchanged. wr_be=0 is a legal no-op.
- Read, RD_LATENCY=1: accept in cycle N; rd_data and rd_data_valid=1 appear in cycle N+1.
- Read, RD_LATENCY=2: an extra output register stage is added; data appears in N+2.
- Reads pipeline back to back at one per cycle.
- rd_data holds its last value when rd_data_valid=0.
- Same-cycle write and read to the same address:
  - WRITE_FIRST=0 returns the pre-write word.
  - WRITE_FIRST=1 returns the lane-merged word: new lanes where wr_be=1, old lanes elsewhere.
  - Different addresses are independent.
- Out-of-range address (≥ DEPTH, non-power-of-2 DEPTH only): write dropped; read returns 0 with rd_data_valid=1.
- Reset mid-operation:
  - In-flight reads are discarded; rd_data_valid goes to 0 immediately.
  - A partially complete clear restarts from address 0.
  - A write in the same cycle as reset assertion is not guaranteed to complete.
- Implementation: the array must map to one inferred memory with one write port and one read port. The lane merge for WRITE_FIRST bypass is done on the bypass path only, not via a read-modify-write of the array.

Test Plan:
- Reset clear, DEPTH=16, CLEAR_ON_RESET=1: release rst_n -> clear_busy high for exactly 16 cycles and rd_ready=0 during it; then read all 16 addresses -> all 0x00000000.
- Lane writes: write 0xAABBCCDD, be=4'b1111, addr 3; then 0x11223344, be=4'b0101, addr 3; read addr 3 -> 0xAA22CC44 one cycle after accept (RD_LATENCY=1).
- Read-during-write: addr 5 holds 0x01020304; same cycle write 0xFFFFFFFF, be=4'b0011 and read addr 5 -> 0x01020304 with WRITE_FIRST=0, 0x0102FFFF with WRITE_FIRST=1; the next read of addr 5 returns 0x0102FFFF in both.
- Latency and streaming, RD_LATENCY=2: back-to-back reads of addr 0..7 -> rd_data_valid high for 8 consecutive cycles starting 2 cycles after the first accept, data in address order.
- Mid-sweep reset, DEPTH=12: pulse rst_n low at clear cycle 7 -> sweep restarts and clear_busy lasts 12 cycles from the second release; a read issued during clear produces no rd_data_valid.
- Width generality, DATA_WIDTH=64, LANE_WIDTH=16, DEPTH=10: write addr 9 with be=4'b1000, data 0xBEEF000000000000 -> read addr 9 returns 0xBEEF000000000000; write to addr 12 is dropped; read of addr 12 returns 0 with valid=1.
